// File: rtl/crc_frame_check.sv
// Pipelined CRC checker for framed 64b/66b-style block streams; blocks pass through with one cycle of latency.
// Optional frame/error statistics counters are built when CRC_FRAME_CHECK_STATS_EN is defined.
module crc_frame_check #(
  parameter int               DATA_W = 64,
  parameter int               CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY   = 8'h07,
  parameter logic [CRC_W-1:0] INIT   = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic              eof_in,
  input  logic [DATA_W-1:0] payload_in,
  input  logic [1:0]        header_in,
  output logic              valid_out,
  output logic              sof_out,
  output logic              eof_out,
  output logic [DATA_W-1:0] payload_out,
  output logic [1:0]        header_out,
  output logic              crc_ok_out,
  output logic              crc_err_out,
  output logic [15:0]       frame_cnt_out,
  output logic [15:0]       err_cnt_out
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t            state_reg, state_next;
  logic [CRC_W-1:0]  crc_reg, crc_next;
  logic [CRC_W-1:0]  crc_base, crc_step;
  logic              bad_reg, bad_next;
  logic              hdr_bad, frame_bad, in_frame_blk;
  logic              ok_next, err_next;
  logic              frame_inc;
  logic [1:0]        err_inc;

  // Unrolled MSB-first LFSR: DATA_W serial steps collapse into one XOR network.
  function automatic logic [CRC_W-1:0] crc_advance(input logic [CRC_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  always_comb begin
    hdr_bad      = (header_in == 2'b00) || (header_in == 2'b11);
    in_frame_blk = sof_in || (state_reg == IN_FRAME);
    // A SOF always restarts from INIT, even when it aborts an open frame.
    crc_base     = (sof_in || state_reg == IDLE) ? INIT : crc_reg;
    crc_step     = crc_advance(crc_base, payload_in);
    frame_bad    = hdr_bad || (bad_reg && !sof_in);

    state_next = state_reg;
    crc_next   = crc_reg;
    bad_next   = bad_reg;
    ok_next    = 1'b0;
    err_next   = 1'b0;
    frame_inc  = 1'b0;
    err_inc    = 2'd0;

    if (valid_in) begin
      if (sof_in && state_reg == IN_FRAME) err_inc = 2'd1;
      if (eof_in) begin
        if (in_frame_blk) begin
          frame_inc = 1'b1;
          if (!frame_bad && crc_step == '0) begin
            ok_next = 1'b1;
          end else begin
            err_next = 1'b1;
            err_inc  = err_inc + 2'd1;
          end
        end else begin
          err_next = 1'b1;
          err_inc  = 2'd1;
        end
        state_next = IDLE;
        crc_next   = INIT;
        bad_next   = 1'b0;
      end else if (in_frame_blk) begin
        state_next = IN_FRAME;
        crc_next   = crc_step;
        bad_next   = frame_bad;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      crc_reg     <= INIT;
      bad_reg     <= 1'b0;
      valid_out   <= 1'b0;
      sof_out     <= 1'b0;
      eof_out     <= 1'b0;
      payload_out <= '0;
      header_out  <= 2'b00;
      crc_ok_out  <= 1'b0;
      crc_err_out <= 1'b0;
    end else begin
      crc_reg     <= crc_next;
      bad_reg     <= bad_next;
      valid_out   <= valid_in;
      sof_out     <= sof_in;
      eof_out     <= eof_in;
      payload_out <= payload_in;
      header_out  <= header_in;
      crc_ok_out  <= ok_next;
      crc_err_out <= err_next;
    end
  end

`ifdef CRC_FRAME_CHECK_STATS_EN
  logic [15:0] frame_cnt_reg, err_cnt_reg;

  // An EOF that also aborts an open frame can add two errors in one cycle.
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt_reg <= 16'd0;
      err_cnt_reg   <= 16'd0;
    end else begin
      frame_cnt_reg <= sat_add(frame_cnt_reg, {1'b0, frame_inc});
      err_cnt_reg   <= sat_add(err_cnt_reg, err_inc);
    end
  end

  assign frame_cnt_out = frame_cnt_reg;
  assign err_cnt_out   = err_cnt_reg;
`else
  logic stats_unused;
  assign stats_unused  = ^{frame_inc, err_inc};
  assign frame_cnt_out = 16'd0;
  assign err_cnt_out   = 16'd0;
`endif

endmodule
